// File: rtl/cmp_pkg.sv
// Shared types and defaults for the compare arbiter: FSM state encoding,
// the comparator result flags, and default operand width / requester count.
package cmp_pkg;

  localparam int DEF_WIDTH = 4;
  localparam int DEF_NREQ  = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CMP  = 2'd1,
    RESP = 2'd2
  } state_t;

  typedef struct packed {
    logic equal;
    logic a_gt;
    logic b_gt;
  } cmp_res_t;

endpackage

// File: rtl/mag_comp_core.sv
// Combinational unsigned magnitude comparator; exactly one result flag is
// high for any operand pair.
module mag_comp_core
  import cmp_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output cmp_res_t         res
);

  assign res.equal = (a == b);
  assign res.a_gt  = (a > b);
  assign res.b_gt  = (a < b);

endmodule

// File: rtl/cmp_arbiter.sv
// Arbitrates NREQ requesters onto one shared comparator (IDLE -> CMP -> RESP).
// Defining CMP_ARBITER_FIXED_PRIO_EN selects fixed lowest-index priority
// instead of the default round-robin search.
module cmp_arbiter
  import cmp_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int NREQ  = DEF_NREQ
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NREQ-1:0]          req_valid,
  input  logic [NREQ*WIDTH-1:0]    req_a,
  input  logic [NREQ*WIDTH-1:0]    req_b,
  output logic [NREQ-1:0]          req_ready,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [$clog2(NREQ)-1:0]  rsp_id,
  output logic                     rsp_equal,
  output logic                     rsp_a_gt,
  output logic                     rsp_b_gt,
  output logic [7:0]               done_cnt
);

  localparam int IDW = $clog2(NREQ);

  state_t           state;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  cmp_res_t         cmp_res;
  cmp_res_t         res_q;
  logic             gnt_found;
  logic [IDW-1:0]   gnt_idx;

`ifndef CMP_ARBITER_FIXED_PRIO_EN
  logic [IDW-1:0]   ptr;
`endif

  // NOTE: every always_comb output gets a default before any conditional
  // assignment, otherwise an unassigned path infers a latch.
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
`ifdef CMP_ARBITER_FIXED_PRIO_EN
    // Scan downward so the lowest requesting index is the last one written.
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (req_valid[i]) begin
        gnt_found = 1'b1;
        gnt_idx   = IDW'(i);
      end
    end
`else
    for (int k = 0; k < NREQ; k++) begin
      if (!gnt_found && req_valid[(int'(ptr) + k) % NREQ]) begin
        gnt_found = 1'b1;
        gnt_idx   = IDW'((int'(ptr) + k) % NREQ);
      end
    end
`endif
  end

  // The strobe is gated by rst_n so it drops the instant reset asserts.
  always_comb begin
    req_ready = '0;
    if (rst_n && state == IDLE && gnt_found) req_ready[gnt_idx] = 1'b1;
  end

  mag_comp_core #(.WIDTH(WIDTH)) u_core (
    .a   (op_a),
    .b   (op_b),
    .res (cmp_res)
  );

  // NOTE: state is updated only with non-blocking assignments so every
  // register samples pre-edge values regardless of statement order.
  // NOTE: operand and result registers are reset too, so nothing stale from
  // an aborted request survives a mid-operation reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      op_a      <= '0;
      op_b      <= '0;
      res_q     <= '0;
      rsp_id    <= '0;
      rsp_valid <= 1'b0;
      done_cnt  <= '0;
`ifndef CMP_ARBITER_FIXED_PRIO_EN
      ptr       <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (gnt_found) begin
            op_a   <= req_a[gnt_idx*WIDTH +: WIDTH];
            op_b   <= req_b[gnt_idx*WIDTH +: WIDTH];
            rsp_id <= gnt_idx;
`ifndef CMP_ARBITER_FIXED_PRIO_EN
            ptr    <= (gnt_idx == IDW'(NREQ - 1)) ? '0 : gnt_idx + IDW'(1);
`endif
            state  <= CMP;
          end
        end
        CMP: begin
          res_q     <= cmp_res;
          rsp_valid <= 1'b1;
          state     <= RESP;
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            done_cnt  <= done_cnt + 8'd1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign rsp_equal = res_q.equal;
  assign rsp_a_gt  = res_q.a_gt;
  assign rsp_b_gt  = res_q.b_gt;

endmodule

// File: tb/tb_cmp_arbiter.sv
// Directed self-checking bench for cmp_arbiter (WIDTH=4, NREQ=4); expected
// grants and flags are hand-derived or from a small compare model.
module tb_cmp_arbiter;

  localparam int WIDTH = 4;
  localparam int NREQ  = 4;

  logic                  clk = 1'b0;
  logic                  rst_n = 1'b0;
  logic [NREQ-1:0]       req_valid = '0;
  logic [NREQ*WIDTH-1:0] req_a = '0;
  logic [NREQ*WIDTH-1:0] req_b = '0;
  logic [NREQ-1:0]       req_ready;
  logic                  rsp_valid;
  logic                  rsp_ready = 1'b0;
  logic [1:0]            rsp_id;
  logic                  rsp_equal;
  logic                  rsp_a_gt;
  logic                  rsp_b_gt;
  logic [7:0]            done_cnt;

  int         n_tests = 0;
  int         n_fail  = 0;
  logic [7:0] exp_done = '0;

  cmp_arbiter #(.WIDTH(WIDTH), .NREQ(NREQ)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_ready (req_ready),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_equal (rsp_equal),
    .rsp_a_gt  (rsp_a_gt),
    .rsp_b_gt  (rsp_b_gt),
    .done_cnt  (done_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not reach its end");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [2:0] flags_of(input logic [3:0] a, input logic [3:0] b);
    return {a == b, a > b, a < b};
  endfunction

  function automatic logic [2:0] flags_now();
    return {rsp_equal, rsp_a_gt, rsp_b_gt};
  endfunction

  // One full transaction with rsp_ready high: grant, CMP, RESP, back to IDLE.
  task automatic run_req(input logic [3:0] vld, input logic [15:0] a, input logic [15:0] b,
                         input int gnt, input logic [2:0] flags, input string tag);
    req_valid = vld;
    req_a     = a;
    req_b     = b;
    rsp_ready = 1'b1;
    #1;
    check({tag, ":grant"}, 32'(req_ready), 32'(1) << gnt);
    tick();
    check({tag, ":cmp_ready"}, 32'(req_ready), 0);
    check({tag, ":cmp_valid"}, 32'(rsp_valid), 0);
    req_a = ~a;
    req_b = ~b;
    tick();
    check({tag, ":rsp_valid"}, 32'(rsp_valid), 1);
    check({tag, ":rsp_id"}, 32'(rsp_id), 32'(gnt));
    check({tag, ":flags"}, 32'(flags_now()), 32'(flags));
    exp_done++;
    tick();
    check({tag, ":rsp_drop"}, 32'(rsp_valid), 0);
    check({tag, ":done"}, 32'(done_cnt), 32'(exp_done));
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, ":ready"}, 32'(req_ready), 0);
    check({tag, ":valid"}, 32'(rsp_valid), 0);
    check({tag, ":id"}, 32'(rsp_id), 0);
    check({tag, ":flags"}, 32'(flags_now()), 0);
    check({tag, ":done"}, 32'(done_cnt), 0);
  endtask

  logic [15:0] av, bv;
  int          id;
  int          rr_order[5];
  int          rr_len;
  logic [2:0]  rr_flags[4];

  initial begin
    // Reset state
    #2;
    check_all_zero("reset");
    tick();
    rst_n = 1'b1;
    tick();
    check("idle_no_req", 32'(req_ready), 0);

    // Exhaustive operand sweep; 256 responses also wrap done_cnt back to 0
    for (int a = 0; a < 16; a++) begin
      for (int b = 0; b < 16; b++) begin
        id = (a + b) % NREQ;
        av = 16'(a) << (4 * id);
        bv = 16'(b) << (4 * id);
        run_req(4'(32'(1) << id), av, bv, id, flags_of(4'(a), 4'(b)), "sweep");
      end
    end
    req_valid = '0;
    #1;
    check("done_wrap", 32'(done_cnt), 0);

    // Single request on requester 0: A=9, B=3 -> a_gt
    run_req(4'b0001, 16'h0009, 16'h0003, 0, 3'b010, "single_agt");
    // Requester 1: A=B=A -> equal
    run_req(4'b0010, 16'h00A0, 16'h00A0, 1, 3'b100, "single_eq");
    // Requester 2: A=0, B=F -> b_gt
    run_req(4'b0100, 16'h0000, 16'h0F00, 2, 3'b001, "single_bgt");
    req_valid = '0;

    // Reset while in CMP with a request from requester 1 in flight
    req_valid = 4'b0010;
    req_a     = 16'h00C0;
    req_b     = 16'h0030;
    rsp_ready = 1'b1;
    #1;
    check("rst_cmp:grant", 32'(req_ready), 32'h2);
    tick();
    check("rst_cmp:in_cmp_id", 32'(rsp_id), 1);
    rst_n     = 1'b0;
    req_valid = 4'hF;
    #1;
    check_all_zero("rst_cmp");
    tick();
    check("rst_hold:ready", 32'(req_ready), 0);
    req_valid = '0;
    rst_n     = 1'b1;
    exp_done  = '0;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("post_rst:no_stale", 32'(rsp_valid), 0);
      check("post_rst:done", 32'(done_cnt), 0);
    end

    // All four requesting continuously, grant order starts at index 0
`ifdef CMP_ARBITER_FIXED_PRIO_EN
    rr_order = '{0, 0, 0, 0, 0};
    rr_len   = 3;
`else
    rr_order = '{0, 1, 2, 3, 0};
    rr_len   = 5;
`endif
    rr_flags = '{3'b001, 3'b001, 3'b100, 3'b010};
    for (int i = 0; i < rr_len; i++) begin
      run_req(4'hF, 16'h8421, 16'h2468, rr_order[i], rr_flags[rr_order[i]], "arb_order");
    end
    req_valid = '0;

    // Backpressure: hold RESP for 10 cycles with everyone else requesting
    req_valid = 4'b1000;
    req_a     = 16'h5000;
    req_b     = 16'h7000;
    rsp_ready = 1'b0;
    #1;
    check("bp:grant", 32'(req_ready), 32'h8);
    tick();
    check("bp:cmp_ready", 32'(req_ready), 0);
    tick();
    req_valid = 4'hF;
    for (int i = 0; i < 10; i++) begin
      #1;
      check("bp:valid", 32'(rsp_valid), 1);
      check("bp:id", 32'(rsp_id), 3);
      check("bp:flags", 32'(flags_now()), 32'(3'b001));
      check("bp:ready", 32'(req_ready), 0);
      check("bp:done", 32'(done_cnt), 32'(exp_done));
      tick();
    end
    rsp_ready = 1'b1;
    #1;
    tick();
    exp_done++;
    check("bp:release_done", 32'(done_cnt), 32'(exp_done));
    check("bp:release_valid", 32'(rsp_valid), 0);
    check("bp:next_grant", 32'(req_ready), 32'h1);
    req_valid = '0;
    #1;
    check("bp:withdrawn", 32'(req_ready), 0);
    tick();
    check("bp:no_accept", 32'(rsp_valid), 0);
    tick();
    check("bp:still_idle", 32'(rsp_valid), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
